// File: rtl/sop_eval_pipe.sv
// Two-stage registered sum-of-products evaluator with a runtime-programmable term table.
// Optional static-1 hazard monitor enabled by defining HAZARD_DET_EN.
module sop_eval_pipe #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 2,
    parameter int HZ_W    = 16,
    localparam int IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out,
    output logic [N_TERMS-1:0] term_hit,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [N_IN-1:0]    cfg_care,
    input  logic [N_IN-1:0]    cfg_pol,
    output logic               hz_flag,
    output logic [HZ_W-1:0]    hz_count
);

    // Handshake: a sample moves when valid & ready are both high at a rising edge.
    // A stage advances when it is empty or its consumer takes its content that edge.
    localparam bit DEF_EN = (N_IN >= 4) && (N_TERMS >= 2);
    localparam logic [N_IN-1:0] T0_CARE = DEF_EN ? N_IN'(4'b0110) : '0;
    localparam logic [N_IN-1:0] T0_POL  = DEF_EN ? N_IN'(4'b0110) : '0;
    localparam logic [N_IN-1:0] T1_CARE = DEF_EN ? N_IN'(4'b1101) : '0;
    localparam logic [N_IN-1:0] T1_POL  = DEF_EN ? N_IN'(4'b1000) : '0;

    logic [N_IN-1:0]    care_q [N_TERMS];
    logic [N_IN-1:0]    care_d [N_TERMS];
    logic [N_IN-1:0]    pol_q  [N_TERMS];
    logic [N_IN-1:0]    pol_d  [N_TERMS];
    logic [N_TERMS-1:0] hit_now;

    logic               s1_valid_q, s1_valid_d;
    logic [N_TERMS-1:0] s1_hit_q, s1_hit_d;
    logic               out_valid_q, out_valid_d;
    logic               out_q, out_d;
    logic [N_TERMS-1:0] term_hit_q, term_hit_d;

    logic s2_adv;
    logic s2_load;

    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign s2_load   = s2_adv && s1_valid_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign term_hit  = term_hit_q;

    // A term with an all-zero care mask is disabled rather than always-true.
    always_comb begin
        hit_now = '0;
        for (int k = 0; k < N_TERMS; k++) begin
            hit_now[k] = (care_q[k] != '0) &&
                         (((in_data ~^ pol_q[k]) & care_q[k]) == care_q[k]);
        end
    end

    always_comb begin
        care_d = care_q;
        pol_d  = pol_q;
        if (cfg_we && (int'(cfg_idx) < N_TERMS)) begin
            care_d[cfg_idx] = cfg_care;
            pol_d[cfg_idx]  = cfg_pol;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hit_d    = s1_hit_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        term_hit_d  = term_hit_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_hit_d = hit_now;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            out_d      = |s1_hit_q;
            term_hit_d = s1_hit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TERMS; k++) begin
                care_q[k] <= (k == 0) ? T0_CARE : (k == 1) ? T1_CARE : '0;
                pol_q[k]  <= (k == 0) ? T0_POL  : (k == 1) ? T1_POL  : '0;
            end
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            term_hit_q  <= '0;
        end else begin
            care_q      <= care_d;
            pol_q       <= pol_d;
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            term_hit_q  <= term_hit_d;
        end
    end

`ifdef HAZARD_DET_EN
    logic [N_IN-1:0] s1_data_q, s1_data_d;
    logic [N_IN-1:0] s2_data_q, s2_data_d;
    logic            prev_valid_q, prev_valid_d;
    logic            hz_flag_q, hz_flag_d;
    logic [HZ_W-1:0] hz_count_q, hz_count_d;
    logic [N_IN-1:0] diff;
    logic            one_bit;
    logic            hz_hit;

    // S2 registers keep the last sample that entered, so they double as the previous sample.
    always_comb begin
        diff         = s1_data_q ^ s2_data_q;
        one_bit      = (diff != '0) && ((diff & (diff - N_IN'(1))) == '0);
        hz_hit       = prev_valid_q && one_bit && out_q && (|s1_hit_q) &&
                       ((term_hit_q & s1_hit_q) == '0);
        s1_data_d    = s1_data_q;
        s2_data_d    = s2_data_q;
        prev_valid_d = prev_valid_q;
        hz_flag_d    = hz_flag_q;
        hz_count_d   = hz_count_q;
        if (in_ready && in_valid) begin
            s1_data_d = in_data;
        end
        if (s2_load) begin
            s2_data_d    = s1_data_q;
            prev_valid_d = 1'b1;
            hz_flag_d    = hz_hit;
            if (hz_hit && (hz_count_q != '1)) begin
                hz_count_d = hz_count_q + HZ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q    <= '0;
            s2_data_q    <= '0;
            prev_valid_q <= 1'b0;
            hz_flag_q    <= 1'b0;
            hz_count_q   <= '0;
        end else begin
            s1_data_q    <= s1_data_d;
            s2_data_q    <= s2_data_d;
            prev_valid_q <= prev_valid_d;
            hz_flag_q    <= hz_flag_d;
            hz_count_q   <= hz_count_d;
        end
    end

    assign hz_flag  = hz_flag_q && out_valid_q;
    assign hz_count = hz_count_q;
`else
    assign hz_flag  = 1'b0;
    assign hz_count = '0;
`endif

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Directed bench for sop_eval_pipe: latency, streaming, stall, config ordering, reset.
// Expected results are hand-derived from the default table (b&c) | (~a&~c&d).
module tb_sop_eval_pipe;

`ifdef HAZARD_DET_EN
    localparam int HZ_ON = 1;
`else
    localparam int HZ_ON = 0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out;
    logic [1:0]  term_hit;
    logic        cfg_we;
    logic [0:0]  cfg_idx;
    logic [3:0]  cfg_care;
    logic [3:0]  cfg_pol;
    logic        hz_flag;
    logic [15:0] hz_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] sb_e;

    sop_eval_pipe #(.N_IN(4), .N_TERMS(2), .HZ_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .term_hit(term_hit),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
        .hz_flag(hz_flag), .hz_count(hz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic eo, input logic [1:0] eh);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && tries < 50) begin
            step();
            tries++;
        end
        check("send_ready", 32'(in_ready), 1);
        if (in_ready) exp_q.push_back({eo, eh});
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: every consumed result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_out", 32'({out, term_hit}), 32'(sb_e));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_pol = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out", 32'(out), 0);
        check("rst_term_hit", 32'(term_hit), 0);
        check("rst_hz_flag", 32'(hz_flag), 0);
        check("rst_hz_count", 32'(hz_count), 0);

        // Single sample: two-cycle latency.
        send(4'b1110, 1'b1, 2'b01);
        check("t1_early_valid", 32'(out_valid), 0);
        step();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_out", 32'(out), 1);
        check("t1_hit", 32'(term_hit), 32'h1);

        // c falls: covering term switches, static-1 hazard candidate.
        send(4'b1010, 1'b1, 2'b10);
        step();
        check("t2_valid", 32'(out_valid), 1);
        check("t2_out", 32'(out), 1);
        check("t2_hit", 32'(term_hit), 32'h2);
        check("t2_hz_flag", 32'(hz_flag), HZ_ON);
        check("t2_hz_count", 32'(hz_count), HZ_ON);
        step();
        check("t2_idle_valid", 32'(out_valid), 0);
        check("t2_idle_flag", 32'(hz_flag), 0);

        // Back-to-back stream.
        send(4'b1110, 1'b1, 2'b01);
        send(4'b1010, 1'b1, 2'b10);
        send(4'b0000, 1'b0, 2'b00);
        send(4'b0110, 1'b1, 2'b01);
        check("t3_s3_valid", 32'(out_valid), 1);
        check("t3_s3", 32'({out, term_hit}), 32'b000);
        step();
        check("t3_s4_valid", 32'(out_valid), 1);
        check("t3_s4", 32'({out, term_hit}), 32'b101);
        step();
        check("t3_drained", 32'(out_valid), 0);
        check("t3_hz_count", 32'(hz_count), 3 * HZ_ON);

        // Stall: two samples held, third waits upstream.
        out_ready = 1'b0;
        send(4'b1110, 1'b1, 2'b01);
        send(4'b1010, 1'b1, 2'b10);
        check("t4_full_ready", 32'(in_ready), 0);
        check("t4_full_valid", 32'(out_valid), 1);
        check("t4_full_out", 32'({out, term_hit}), 32'b101);
        in_valid = 1'b1;
        in_data  = 4'b0000;
        exp_q.push_back(3'b000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_stall_ready", 32'(in_ready), 0);
            check("t4_stall_valid", 32'(out_valid), 1);
            check("t4_stall_out", 32'({out, term_hit}), 32'b101);
        end
        out_ready = 1'b1;
        #1;
        check("t4_resume_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("t4_queue_empty", 32'(exp_q.size()), 0);
        check("t4_hz_count", 32'(hz_count), 4 * HZ_ON);

        // Config write in the same cycle as a sample: sample sees the old table.
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_care = 4'b0001; cfg_pol = 4'b0000;
        in_valid = 1'b1; in_data = 4'b0000;
        check("t5_ready", 32'(in_ready), 1);
        exp_q.push_back(3'b000);
        step();
        cfg_we = 1'b0;
        in_valid = 1'b0;
        send(4'b0000, 1'b1, 2'b01);
        check("t5_old_table", 32'({out_valid, out, term_hit}), 32'b1000);
        step();
        check("t5_new_table", 32'({out_valid, out, term_hit}), 32'b1101);
        step();
        check("t5_queue_empty", 32'(exp_q.size()), 0);

        // Reset with two samples in flight and a colliding config write.
        out_ready = 1'b0;
        send(4'b1110, 1'b1, 2'b01);
        send(4'b1010, 1'b1, 2'b10);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_care = 4'b0001; cfg_pol = 4'b0000;
        step();
        rst = 1'b0;
        cfg_we = 1'b0;
        exp_q.delete();
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_out", 32'({out, term_hit}), 0);
        check("t6_hz_flag", 32'(hz_flag), 0);
        check("t6_hz_count", 32'(hz_count), 0);
        out_ready = 1'b1;
        send(4'b0000, 1'b0, 2'b00);
        send(4'b1110, 1'b1, 2'b01);
        check("t6_default_table", 32'({out_valid, out, term_hit}), 32'b1000);
        step();
        step();
        step();
        check("t6_queue_empty", 32'(exp_q.size()), 0);
        check("t6_hz_count_end", 32'(hz_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
